// File: rtl/cpu_types_pkg.sv
// Shared CPU memory-interface types: data word, RAM handshake state and
// the arbiter FSM encoding.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    IFETCH  = 3'd1,
    DACCESS = 3'd2,
    DONE    = 3'd3,
    FAULT   = 3'd4
  } arb_state_t;

endpackage

// File: rtl/timeout_counter.sv
// Grant watchdog: counts cycles spent waiting on the RAM and flags when the
// count reaches TIMEOUT-1. Holds at the limit so the flag stays up.
module timeout_counter #(
  parameter int TIMEOUT = 16
) (
  input  logic CLK,
  input  logic nRST,
  input  logic clear,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT) + 1;

  logic [CW-1:0] cnt_q;

  assign expired = (cnt_q == CW'(TIMEOUT - 1));

  // Clear wins over count; saturate once the limit is reached.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (en && !expired) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/memory_arbiter.sv
// Fetch/data arbiter in front of a single RAM port. Data requests beat
// instruction fetches; each transfer is IDLE -> grant -> DONE, with a
// one-cycle hit pulse in DONE. RAM errors or a stalled grant park the
// block in FAULT until reset.
module memory_arbiter
  import cpu_types_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic      CLK,
  input  logic      nRST,
  input  logic      iREN,
  input  word_t     iaddr,
  input  logic      dREN,
  input  logic      dWEN,
  input  word_t     daddr,
  input  word_t     dstore,
  output logic      ihit,
  output word_t     iload,
  output logic      dhit,
  output word_t     dload,
  output logic      ramREN,
  output logic      ramWEN,
  output word_t     ramaddr,
  output word_t     ramstore,
  input  word_t     ramload,
  input  ramstate_t ramstate,
  output logic      fault
);

  arb_state_t state_q;
  logic       ihit_q, dhit_q, ramREN_q, ramWEN_q, fault_q;
  word_t      iload_q, dload_q, ramaddr_q, ramstore_q;
  logic       in_grant, expired;

  assign in_grant = (state_q == IFETCH) || (state_q == DACCESS);

  // Counter sits at zero while idle, so every grant starts from a clean count.
  timeout_counter #(.TIMEOUT(TIMEOUT)) u_tmo (
    .CLK     (CLK),
    .nRST    (nRST),
    .clear   (state_q == IDLE),
    .en      (in_grant),
    .expired (expired)
  );

  // Arbiter FSM; all interface outputs are registered here.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q    <= IDLE;
      ihit_q     <= 1'b0;
      dhit_q     <= 1'b0;
      ramREN_q   <= 1'b0;
      ramWEN_q   <= 1'b0;
      fault_q    <= 1'b0;
      iload_q    <= '0;
      dload_q    <= '0;
      ramaddr_q  <= '0;
      ramstore_q <= '0;
    end else begin
      ihit_q <= 1'b0;
      dhit_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (dREN || dWEN) begin
            // Both enables together is a write.
            state_q    <= DACCESS;
            ramaddr_q  <= daddr;
            ramWEN_q   <= dWEN;
            ramREN_q   <= !dWEN;
            ramstore_q <= dWEN ? dstore : '0;
          end else if (iREN) begin
            state_q    <= IFETCH;
            ramaddr_q  <= iaddr;
            ramREN_q   <= 1'b1;
            ramWEN_q   <= 1'b0;
            ramstore_q <= '0;
          end
        end
        IFETCH, DACCESS: begin
          if (ramstate == ACCESS) begin
            state_q  <= DONE;
            ramREN_q <= 1'b0;
            ramWEN_q <= 1'b0;
            if (state_q == IFETCH) begin
              iload_q <= ramload;
              ihit_q  <= 1'b1;
            end else begin
              // Stores complete with a hit but leave dload alone.
              if (!ramWEN_q) dload_q <= ramload;
              dhit_q <= 1'b1;
            end
          end else if ((ramstate == ERROR) || expired) begin
            state_q  <= FAULT;
            ramREN_q <= 1'b0;
            ramWEN_q <= 1'b0;
            fault_q  <= 1'b1;
          end
        end
        // Requests are deliberately not sampled here.
        DONE:    state_q <= IDLE;
        FAULT:   fault_q <= 1'b1;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ihit     = ihit_q;
  assign dhit     = dhit_q;
  assign iload    = iload_q;
  assign dload    = dload_q;
  assign ramREN   = ramREN_q;
  assign ramWEN   = ramWEN_q;
  assign ramaddr  = ramaddr_q;
  assign ramstore = ramstore_q;
  assign fault    = fault_q;

endmodule

// File: doc/memory_arbiter.md
Name: memory_arbiter

Overview:
- Responder end of the CPU fetch/data interface.
- Accepts instruction-fetch requests (driven by the program counter's address) and data load/store requests from the datapath.
- Serialises them onto the single RAM port and returns the fetched/loaded words with one-cycle ihit/dhit pulses. These pulses are the ihit/dhit consumed by the program counter and the request logic.
- Sits between the datapath and the RAM.

Parameters:
TIMEOUT, 16, cycles a granted RAM request may wait for ACCESS before the arbiter declares a fault (min 2)

Ports:
CLK  in  1  system clock, rising edge
nRST  in  1  asynchronous active-low reset
iREN  in  1  instruction fetch request
iaddr  in  32  fetch address (word_t)
dREN  in  1  data read request
dWEN  in  1  data write request
daddr  in  32  data address
dstore  in  32  store data
ihit  out  1  one-cycle pulse: iload valid
iload  out  32  fetched instruction
dhit  out  1  one-cycle pulse: load data valid / store complete
dload  out  32  loaded data
ramREN  out  1  RAM read enable
ramWEN  out  1  RAM write enable
ramaddr  out  32  RAM address
ramstore  out  32  RAM write data
ramload  in  32  RAM read data
ramstate  in  2  ramstate_t: FREE, BUSY, ACCESS, ERROR
fault  out  1  sticky error flag

Behaviour:
- Reset (async, nRST=0, any state): state=IDLE; counter=0; every output 0.
- States: IDLE, IFETCH, DACCESS, DONE, FAULT.
- IDLE:
  - dREN|dWEN -> DACCESS. Latch daddr, dstore, op (write if dWEN, else read).
  - else iREN -> IFETCH. Latch iaddr.
  - else stay.
  - Data wins over instruction when both are pending.
  - dREN & dWEN together is treated as a write.
- IFETCH/DACCESS:
  - RAM outputs are registered from latched values: ramaddr = latched addr; ramREN=1 for IFETCH or data read; ramWEN=1 and ramstore = latched data for a data write.
  - Request inputs are ignored; changes mid-grant have no effect.
  - ramstate==ACCESS sampled at a rising edge -> DONE. Capture ramload into iload (IFETCH) or dload (data read), and pulse the matching hit.
  - ramstate==ERROR -> FAULT.
  - Counter increments each cycle in the grant state. counter reaching TIMEOUT-1 without ACCESS -> FAULT.
- DONE:
  - Lasts exactly 1 cycle; ihit or dhit = 1; RAM enables = 0.
  - Requests are not sampled in DONE, so the requester can update its request at this edge without a duplicate grant.
  - -> IDLE.
- Hit timing: minimum latency from request asserted in IDLE to hit is 2 cycles when RAM returns ACCESS in the first grant cycle. A RAM that is BUSY for N cycles adds N cycles.
- Data outputs: iload/dload hold their last captured value until the next capture. A store does not change dload.
- FAULT: fault=1; RAM enables=0; no hits; leaves only by reset.
- Counter is sized $clog2(TIMEOUT)+1 and cleared on every grant entry.
- Throughput: at most one transfer per 3 cycles (IDLE, grant, DONE).

Decomposition:
- cpu_types_pkg: word_t (32b), ramstate_t enum {FREE, BUSY, ACCESS, ERROR}, arb_state_t enum {IDLE, IFETCH, DACCESS, DONE, FAULT}.
- Sub-module timeout_counter(CLK, nRST, clear, en, expired; parameter TIMEOUT).

Test Plan:
- Reset mid-DACCESS with ramWEN=1: assert nRST=0 -> all outputs 0 immediately, before the next edge. Release -> IDLE, fault=0.
- Fetch: iREN=1, iaddr=0x0000_0040; RAM ACCESS on the first grant cycle with ramload=0x2002_0005 -> ramREN=1, ramaddr=0x40 in cycle 1. ihit=1, iload=0x2002_0005 in cycle 2 only. Duplicate fetch does not start until cycle 3.
- Simultaneous: iREN=1 (0x44) and dWEN=1, daddr=0x100, dstore=0xDEAD_BEEF -> write granted first (ramWEN=1, ramstore=0xDEADBEEF), dhit pulses, dload unchanged. Fetch of 0x44 follows, ihit 3 cycles after dhit.
- Wait states: dREN=1, daddr=0x200; ramstate BUSY 3 cycles, then ACCESS with ramload=0x1234_5678 -> dhit on cycle 5, dload=0x12345678. Exactly one dhit cycle.
- Timeout: iREN=1, ramstate held BUSY -> fault=1 after TIMEOUT cycles (16 at default) in IFETCH. RAM enables drop. No ihit thereafter, even if ACCESS appears.
- ERROR: dREN=1 with ramstate=ERROR in the grant cycle -> FAULT next cycle, dhit never asserted, fault stays 1 until nRST.
